// File: rtl/nios_fprint_scratchpad_arbiter.sv
// Round-robin arbiter sharing one scratchpad RAM between the Nios data master (port 0)
// and the fingerprint/DMA engine (port 1). Optional port-1 lock: define SPAD_ARB_LOCK_EN.
//
// Lock FSM (SPAD_ARB_LOCK_EN only):
//   state | meaning
//   ARB   | normal round-robin arbitration between both ports
//   LOCK1 | port 1 holds exclusive grant (atomic read-modify-write), port 0 waits
module nios_fprint_scratchpad_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   p0_address,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W-1:0]   p0_writedata,
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,

    input  logic [ADDR_W-1:0]   p1_address,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,
    input  logic                p1_lock,

    output logic [ADDR_W-1:0]   spad_address,
    output logic [DATA_W/8-1:0] spad_byteenable,
    output logic                spad_chipselect,
    output logic                spad_write,
    output logic [DATA_W-1:0]   spad_writedata,
    input  logic [DATA_W-1:0]   spad_readdata,
    output logic                spad_clken,
    output logic                spad_reset_req
);

    logic                  req0;
    logic                  req1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  last_grant;
    logic                  lock_hold;
    logic                  rd_accept;
    logic                  rd_port;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_port;

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

`ifdef SPAD_ARB_LOCK_EN
    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } lock_state_t;

    lock_state_t state;
    lock_state_t state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (gnt1 && p1_lock) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK1: begin
                // Release on the unlocking command, or when the engine drops lock while idle.
                if (!p1_lock && (gnt1 || !req1)) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    assign lock_hold = (state == LOCK1);
`else
    logic unused_p1_lock;
    assign unused_p1_lock = p1_lock;
    assign lock_hold      = 1'b0;
`endif

    // last_grant == 1 means port 1 was served last, so port 0 wins the next conflict.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (lock_hold) begin
                gnt1 = req1;
            end else if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end

    assign p0_waitrequest = req0 & ~gnt0;
    assign p1_waitrequest = req1 & ~gnt1;

    assign spad_address    = gnt1 ? p1_address    : p0_address;
    assign spad_byteenable = gnt1 ? p1_byteenable : p0_byteenable;
    assign spad_writedata  = gnt1 ? p1_writedata  : p0_writedata;
    assign spad_chipselect = gnt0 | gnt1;
    assign spad_write      = (gnt0 & p0_write) | (gnt1 & p1_write);
    assign spad_clken      = 1'b1;
    assign spad_reset_req  = 1'b0;

    // A read with write also set is treated as a write and returns nothing.
    assign rd_accept = (gnt0 & p0_read & ~p0_write) | (gnt1 & p1_read & ~p1_write);
    assign rd_port   = gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_port  <= '0;
        end else begin
            pipe_valid[0] <= rd_accept;
            pipe_port[0]  <= rd_port;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_port[i]  <= pipe_port[i-1];
            end
        end
    end

    assign p0_readdatavalid = pipe_valid[RD_LATENCY-1] & ~pipe_port[RD_LATENCY-1];
    assign p1_readdatavalid = pipe_valid[RD_LATENCY-1] &  pipe_port[RD_LATENCY-1];
    assign p0_readdata      = spad_readdata;
    assign p1_readdata      = spad_readdata;

endmodule

// File: tb/tb_nios_fprint_scratchpad_arbiter.sv
// Bench for nios_fprint_scratchpad_arbiter: directed scenarios plus random traffic against
// a reference model built from the arbitration rules, a golden memory and a return queue.
module tb_nios_fprint_scratchpad_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] p0_address, p1_address;
    logic [3:0]        p0_byteenable, p1_byteenable;
    logic              p0_read, p0_write, p1_read, p1_write, p1_lock;
    logic [31:0]       p0_writedata, p1_writedata;
    logic              p0_waitrequest, p1_waitrequest;
    logic [31:0]       p0_readdata, p1_readdata;
    logic              p0_readdatavalid, p1_readdatavalid;
    logic [ADDR_W-1:0] spad_address;
    logic [3:0]        spad_byteenable;
    logic              spad_chipselect, spad_write, spad_clken, spad_reset_req;
    logic [31:0]       spad_writedata, spad_readdata;

    nios_fprint_scratchpad_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
        .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
        .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
        .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
        .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid), .p1_lock(p1_lock),
        .spad_address(spad_address), .spad_byteenable(spad_byteenable),
        .spad_chipselect(spad_chipselect), .spad_write(spad_write),
        .spad_writedata(spad_writedata), .spad_readdata(spad_readdata),
        .spad_clken(spad_clken), .spad_reset_req(spad_reset_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad RAM: synchronous write, read data appears the cycle after the access.
    logic [31:0] ram [0:4095];
    logic [31:0] ram_q;
    assign spad_readdata = ram_q;
    always @(posedge clk) begin
        if (spad_chipselect) begin
            if (spad_write) begin
                for (int b = 0; b < 4; b++)
                    if (spad_byteenable[b]) ram[spad_address][8*b +: 8] <= spad_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[spad_address];
            end
        end
    end

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } rd_t;

    logic [31:0] gmem [0:4095];
    rd_t         exp_q[$];
    logic        m_last;
    logic        m_locked;
    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [31:0] last_p0_data;
    logic [31:0] last_p1_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drv0(input logic r, input logic w, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        p0_read = r; p0_write = w; p0_address = a; p0_byteenable = be; p0_writedata = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        p1_read = r; p1_write = w; p1_address = a; p1_byteenable = be; p1_writedata = d;
    endtask

    task automatic access(input logic port, input logic r, input logic w, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        rd_t e;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) gmem[a][8*b +: 8] = d[8*b +: 8];
        end else if (r) begin
            e.port = port;
            e.data = gmem[a];
            e.due  = cyc + RD_LAT;
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: inputs already driven, check mid-cycle, advance model, step clock.
    task automatic tick();
        logic req0, req1, g0, g1, e_rdv0, e_rdv1;
        logic [31:0] e_data;
        if (!reset_n) begin
            exp_q.delete();
            m_last   = 1'b1;
            m_locked = 1'b0;
        end
        #3;
        req0 = p0_read | p0_write;
        req1 = p1_read | p1_write;
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset_n) begin
            if (m_locked) begin
                g1 = req1;
            end else if (req0 && req1) begin
                g0 = (m_last == 1'b1);
                g1 = !g0;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
        e_rdv0 = 1'b0;
        e_rdv1 = 1'b0;
        e_data = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].port) e_rdv1 = 1'b1;
            else               e_rdv0 = 1'b1;
            e_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        chk("p0_waitrequest", p0_waitrequest, req0 & ~g0);
        chk("p1_waitrequest", p1_waitrequest, req1 & ~g1);
        chk("spad_chipselect", spad_chipselect, g0 | g1);
        chk("spad_write", spad_write, (g0 & p0_write) | (g1 & p1_write));
        chk("p0_readdatavalid", p0_readdatavalid, e_rdv0);
        chk("p1_readdatavalid", p1_readdatavalid, e_rdv1);
        if (e_rdv0) begin
            chk("p0_readdata", p0_readdata, e_data);
            last_p0_data = p0_readdata;
        end
        if (e_rdv1) begin
            chk("p1_readdata", p1_readdata, e_data);
            last_p1_data = p1_readdata;
        end
        if (g0) access(1'b0, p0_read, p0_write, p0_address, p0_byteenable, p0_writedata);
        if (g1) access(1'b1, p1_read, p1_write, p1_address, p1_byteenable, p1_writedata);
        if (g0) m_last = 1'b0;
        if (g1) m_last = 1'b1;
`ifdef SPAD_ARB_LOCK_EN
        if (!m_locked) begin
            if (g1 && p1_lock) m_locked = 1'b1;
        end else if (!p1_lock && (g1 || !req1)) begin
            m_locked = 1'b0;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_last   = 1'b1;
        m_locked = 1'b0;
        ram_q    = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]  = 32'h1000_0000 + i;
            gmem[i] = 32'h1000_0000 + i;
        end
        reset_n = 1'b0;
        p1_lock = 1'b0;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);

        // Reset: no grants, waitrequest follows requests.
        tick();
        drv0(1, 0, 12'h003, 4'hF, 0);
        drv1(0, 1, 12'h004, 4'hF, 32'h1234_5678);
        tick();
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        chk("spad_clken", spad_clken, 1'b1);
        chk("spad_reset_req", spad_reset_req, 1'b0);

        // Port 0 write then read back.
        drv0(0, 1, 12'h010, 4'hF, 32'hDEAD_BEEF); tick();
        drv0(1, 0, 12'h010, 4'hF, 0);             tick();
        drv0(0, 0, 0, 0, 0);                      tick();
        chk("p0_readback_deadbeef", last_p0_data, 32'hDEAD_BEEF);

        // Both ports reading continuously straight out of reset.
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        drv0(1, 0, 12'h000, 4'hF, 0);
        drv1(1, 0, 12'h001, 4'hF, 0);
        repeat (8) tick();
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("alt_p0_data", last_p0_data, 32'h1000_0000);
        chk("alt_p1_data", last_p1_data, 32'h1000_0001);

        // Byte-enable merge across ports.
        drv0(0, 1, 12'h020, 4'hF, 32'hFFFF_FFFF); tick();
        drv0(0, 0, 0, 0, 0);
        drv1(0, 1, 12'h020, 4'h1, 32'h0000_00AA); tick();
        drv1(0, 0, 0, 0, 0);
        drv0(1, 0, 12'h020, 4'hF, 0);             tick();
        drv0(0, 0, 0, 0, 0);                      tick();
        chk("byteenable_merge", last_p0_data, 32'hFFFF_FFAA);

        // Port 1 back-to-back reads of the last word.
        drv1(1, 0, 12'hFFF, 4'hF, 0);
        repeat (4) tick();
        drv1(0, 0, 0, 0, 0);
        tick();
        chk("last_word_read", last_p1_data, 32'h1000_0FFF);

        // Reset pulse drops an in-flight read; port 0 wins the first conflict afterwards.
        drv1(1, 0, 12'h005, 4'hF, 0); tick();
        drv1(0, 0, 0, 0, 0);
        reset_n = 1'b0;               tick();
        reset_n = 1'b1;
        drv0(1, 0, 12'h006, 4'hF, 0);
        drv1(1, 0, 12'h007, 4'hF, 0);
        #3;
        chk("post_reset_p0_first", p0_waitrequest, 1'b0);
        chk("post_reset_p1_waits", p1_waitrequest, 1'b1);
        #1;
        tick();
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        repeat (2) tick();

        // Random traffic, including illegal read+write (write wins) and random lock.
        for (int n = 0; n < 400; n++) begin
            drv0(($urandom % 3) == 0, ($urandom % 4) == 0,
                 ($urandom % 8 == 0) ? 12'hFFF : 12'($urandom_range(0, 15)),
                 4'($urandom), $urandom);
            drv1(($urandom % 3) == 0, ($urandom % 4) == 0,
                 ($urandom % 8 == 0) ? 12'hFFF : 12'($urandom_range(0, 15)),
                 4'($urandom), $urandom);
            p1_lock = ($urandom % 4) == 0;
            tick();
        end
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        p1_lock = 1'b0;
        repeat (3) tick();

`ifdef SPAD_ARB_LOCK_EN
        // Atomic read-modify-write window on port 1.
        drv0(0, 1, 12'h050, 4'hF, 32'h5555_0000); tick();
        drv0(1, 0, 12'h050, 4'hF, 0);
        drv1(1, 0, 12'h040, 4'hF, 0); p1_lock = 1'b1; tick();
        drv1(0, 0, 0, 0, 0);
        repeat (2) tick();
        drv1(0, 1, 12'h040, 4'hF, 32'h0000_0040); p1_lock = 1'b0;
        #3;
        chk("lock_p0_waits_on_unlock", p0_waitrequest, 1'b1);
        #1;
        tick();
        drv1(0, 0, 0, 0, 0);
        #3;
        chk("lock_p0_granted_after", p0_waitrequest, 1'b0);
        #1;
        tick();
        drv0(0, 0, 0, 0, 0);
        repeat (2) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nios_fprint_scratchpad_arbiter.md
Name: nios_fprint_scratchpad_arbiter

Overview:
- Two-requester arbiter that shares one single-port per-core scratchpad RAM (4096 x 32, byte-enabled, unregistered q) between the Nios data master (port 0) and the fingerprint/DMA engine (port 1).
- Presents two Avalon-MM slave ports with waitrequest and readdatavalid, and drives the RAM's address/byteenable/chipselect/write/writedata/clken/reset_req.
- Round-robin fairness; tracks pipelined read returns to the correct port.

Parameters:
- ADDR_W, 12, word address width (RAM depth 2^ADDR_W).
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- RD_LATENCY, 1, RAM read latency in cycles; legal values 1 or 2 (2 when RAM output is registered).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- p0_address  in  ADDR_W  port 0 word address
- p0_byteenable  in  DATA_W/8  port 0 byte enables
- p0_read  in  1  port 0 read request
- p0_write  in  1  port 0 write request
- p0_writedata  in  DATA_W  port 0 write data
- p0_waitrequest  out  1  port 0 stall
- p0_readdata  out  DATA_W  port 0 read data
- p0_readdatavalid  out  1  port 0 read data valid
- p1_* (address, byteenable, read, write, writedata, waitrequest, readdata, readdatavalid)  same as p0_*, for port 1
- p1_lock  in  1  hold grant on port 1 (only with SPAD_ARB_LOCK_EN)
- spad_address  out  ADDR_W  RAM address
- spad_byteenable  out  DATA_W/8  RAM byte enables
- spad_chipselect  out  1  RAM select
- spad_write  out  1  RAM write
- spad_writedata  out  DATA_W  RAM write data
- spad_readdata  in  DATA_W  RAM q
- spad_clken  out  1  RAM clock enable, tied 1
- spad_reset_req  out  1  RAM reset request, tied 0

Behaviour:
- Request: req_k = pk_read | pk_write. Setting both read and write on one port is illegal; write takes precedence and no readdatavalid is returned.
- Grant is combinational each cycle from the requests and the registered last_grant. The granted port's command drives spad_* in the same cycle. spad_chipselect = grant valid; spad_write = granted write.
- pk_waitrequest = req_k & ~grant_k. It is combinational; no command is accepted while waitrequest is high.
- Single requester: granted every cycle, giving back-to-back throughput of 1 access/cycle.
- Both requesting: grant goes to the port not in last_grant. last_grant updates on every accepted command.
- Read return: each accepted read pushes {valid, port} into a RD_LATENCY-deep shift pipeline. When an entry exits, the matching pk_readdatavalid is 1 for exactly one cycle.
- pk_readdata = spad_readdata on both ports; it is meaningful only when readdatavalid is high.
- Latency: read accepted in cycle N gives readdatavalid in cycle N+RD_LATENCY. Returns are in-order, with no reordering between ports.
- Writes complete in the accept cycle and produce no response.
- Idle: spad_chipselect=0, spad_write=0; address, byteenable and writedata are don't-care but driven from port 0.
- Reset (asynchronous assert, synchronous release):
  - last_grant=1, so port 0 wins the first conflict.
  - Read pipeline cleared; both readdatavalid=0.
  - While reset_n=0, grant is forced off: spad_chipselect=0, pk_waitrequest=req_k.
  - Reads in flight at reset are dropped with no readdatavalid.
- State: last_grant (1b), read pipeline (RD_LATENCY x 2b), lock FSM (below).

Optional Feature:
- Macro: SPAD_ARB_LOCK_EN.
- When defined:
  - FSM has states ARB and LOCK1.
  - ARB -> LOCK1 when port 1 is granted a command with p1_lock=1.
  - In LOCK1, port 1 has exclusive grant and port 0 waits even if port 1 is idle.
  - LOCK1 -> ARB on the first accepted port-1 command with p1_lock=0, or when p1_lock drops while port 1 is idle.
  - Reset -> ARB.
  - Supports atomic read-modify-write by the engine.
- When undefined: p1_lock is ignored and arbitration is pure round-robin.

Test Plan:
- Port 0 writes 0xDEADBEEF to 0x010 with byteenable 0xF, then reads 0x010 -> waitrequest 0 both cycles; readdatavalid on p0 one cycle after the read with readdata 0xDEADBEEF; p1_readdatavalid stays 0.
- Both ports read continuously (p0 at 0x000, p1 at 0x001) from reset -> grants alternate p0,p1,p0,p1; each port stalls every other cycle; readdatavalid strictly alternates with correct data.
- Port 0 writes 0xFFFFFFFF to 0x020, then port 1 writes 0x000000AA with byteenable 0x1, then port 0 reads 0x020 -> 0xFFFFFFAA.
- Port 1 reads 0xFFF back-to-back with port 0 idle -> no waitrequest; readdatavalid every cycle; address wraps nothing (0xFFF is the last word, no overflow).
- reset_n pulsed low one cycle after a p1 read is accepted -> no p1_readdatavalid; after release, a simultaneous p0/p1 request grants p0 first.
- With SPAD_ARB_LOCK_EN: p1 reads 0x040 with lock=1, idles 2 cycles with lock=1, then writes 0x040 with lock=0 -> p0 requests during this window see waitrequest=1 throughout and are granted the cycle after the unlocking write.
